// File: rtl/imem_stream_loader.sv
// Boot loader: takes a framed byte stream (16-bit word count, big-endian data words,
// XOR checksum), writes the words into instruction memory and stalls the CPU until the frame checks good.
module imem_stream_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [15:0]         count;
    logic [7:0]          acc;
    logic [1:0]          byte_idx;
    logic [23:0]         word_buf;
    logic                accept;
    logic                last_word;
    logic [ADDR_WIDTH:0] words_inc;
    logic [16:0]         new_count;

    assign accept    = in_valid & in_ready;
    assign words_inc = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign new_count = {1'b0, count[15:8], in_data};
    assign last_word = (17'(words_inc) == {1'b0, count});

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            S_CNT_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (new_count > DEPTH)       state_next = S_ERROR;
                    else if (new_count == 17'd0) state_next = S_CHK;
                    else                         state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_idx == 2'd3 && last_word) state_next = S_CHK;
            end
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_data == acc) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
                if (reload) state_next = S_CNT_HI;
            end
            S_ERROR: begin
                load_error = 1'b1;
                if (reload) state_next = S_CNT_HI;
            end
            default: state_next = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_CNT_HI;
            count        <= '0;
            acc          <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            state   <= state_next;
            imem_we <= 1'b0;
            case (state)
                S_CNT_HI: if (accept) count[15:8] <= in_data;
                S_CNT_LO: if (accept) count[7:0]  <= in_data;
                S_DATA: begin
                    if (accept) begin
                        acc      <= acc ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        // The first three bytes of a word are buffered; the fourth completes the write.
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                            imem_wdata   <= {word_buf, in_data};
                            words_loaded <= words_inc;
                        end else begin
                            word_buf <= {word_buf[15:0], in_data};
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (reload) begin
                        count        <= '0;
                        acc          <= '0;
                        byte_idx     <= '0;
                        word_buf     <= '0;
                        words_loaded <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
